dkong_wav_rom_sched: RTL

//   Shares the single wave-sample ROM read port (19-bit byte address) between NUM_CH

---
 rtl/dkong_wav_rom_sched_if.sv | 30 +++
 rtl/dkong_wav_rom_sched.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dkong_wav_rom_sched_if.sv
// Wave-sample ROM scheduler bus: requester side plus the shared ROM port.
// The slave modport is the scheduler; master is the players/ROM side.
interface dkong_wav_rom_sched_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic [NUM_CH-1:0]        I_REQ;
  logic [NUM_CH*ADDR_W-1:0] I_ADDR;
  logic [NUM_CH*DATA_W-1:0] O_DATA;
  logic [NUM_CH-1:0]        O_VALID;
  logic [NUM_CH-1:0]        O_OVR;
  logic                     O_ERR;
  logic                     O_ROM_REQ;
  logic [ADDR_W-1:0]        O_ROM_AB;
  logic                     I_ROM_ACK;
  logic [DATA_W-1:0]        I_ROM_DATA;

  modport slave (
    input  I_REQ, I_ADDR, I_ROM_ACK, I_ROM_DATA,
    output O_DATA, O_VALID, O_OVR, O_ERR,
    output O_ROM_REQ, O_ROM_AB
  );

  modport master (
    output I_REQ, I_ADDR, I_ROM_ACK, I_ROM_DATA,
    input  O_DATA, O_VALID, O_OVR, O_ERR,
    input  O_ROM_REQ, O_ROM_AB
  );
endinterface

// File: rtl/dkong_wav_rom_sched.sv
// Shares one wave ROM read port between NUM_CH sample requesters.
// DKWAV_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module dkong_wav_rom_sched #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int ACK_TMO = 255
) (
  input logic I_CLK,
  input logic I_RST,
  dkong_wav_rom_sched_if.slave bus
);
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] TMO_LAST = 8'(ACK_TMO - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                   state_q, state_d;
  logic [NUM_CH-1:0]        pend_q, pend_d;
  logic [NUM_CH*ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic [NUM_CH-1:0]        ovr_q, ovr_d;
  logic                     err_q, err_d;
  logic                     rreq_q, rreq_d;
  logic [ADDR_W-1:0]        ab_q, ab_d;
  logic [CH_W-1:0]          gnt_q, gnt_d;
  logic [CH_W-1:0]          rr_q, rr_d;
  logic [7:0]               tmo_q, tmo_d;

  logic            sel_vld;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] rr_nxt;
  logic            grant;

`ifdef DKWAV_FIXED_PRIO_EN
  // Lowest pending index wins; the pointer never moves.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        sel_vld = 1'b1;
        sel     = CH_W'(k);
      end
    end
  end

  assign rr_nxt = '0;
`else
  // Scan downward so the nearest channel at/after rr is chosen last.
  always_comb begin
    int idx;
    sel_vld = 1'b0;
    sel     = '0;
    idx     = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (pend_q[idx]) begin
        sel_vld = 1'b1;
        sel     = CH_W'(idx);
      end
    end
  end

  assign rr_nxt = (gnt_q == CH_LAST) ? '0 : gnt_q + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = '0;
    ovr_d   = '0;
    err_d   = 1'b0;
    rreq_d  = rreq_q;
    ab_d    = ab_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    tmo_d   = tmo_q;
    grant   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          grant       = 1'b1;
          rreq_d      = 1'b1;
          ab_d        = addr_q[int'(sel)*ADDR_W +: ADDR_W];
          pend_d[sel] = 1'b0;
          tmo_d       = '0;
          gnt_d       = sel;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.I_ROM_ACK) begin
          rreq_d         = 1'b0;
          valid_d[gnt_q] = 1'b1;
          rr_d           = rr_nxt;
          state_d        = S_IDLE;
          data_d[int'(gnt_q)*DATA_W +: DATA_W] = bus.I_ROM_DATA;
        end else if (tmo_q == TMO_LAST) begin
          rreq_d  = 1'b0;
          err_d   = 1'b1;
          rr_d    = rr_nxt;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request being granted this edge is not an overrun.
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.I_REQ[i]) begin
        ovr_d[i]  = pend_q[i] & ~(grant & (sel == CH_W'(i)));
        pend_d[i] = 1'b1;
        addr_d[i*ADDR_W +: ADDR_W] = bus.I_ADDR[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
      ovr_q   <= '0;
      err_q   <= 1'b0;
      rreq_q  <= 1'b0;
      ab_q    <= '0;
      gnt_q   <= '0;
      rr_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
      rreq_q  <= rreq_d;
      ab_q    <= ab_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.O_DATA    = data_q;
  assign bus.O_VALID   = valid_q;
  assign bus.O_OVR     = ovr_q;
  assign bus.O_ERR     = err_q;
  assign bus.O_ROM_REQ = rreq_q;
  assign bus.O_ROM_AB  = ab_q;
endmodule
